// File: rtl/player_ctrl.sv
// player_ctrl -- player footprint position controller for the maze stages.
// Takes a direction request on a movement tick, scans the 16 cells of the
// candidate 4x4 footprint against the map one cell per cycle, then commits
// or rejects the move and flags arrival at the goal.
// Optional feature macro: DIAG_MOVE_EN (two orthogonal keys form a diagonal move).

module player_ctrl #(
   parameter int START_X = 1,
   parameter int START_Y = 1,
   parameter int GOAL_X  = 35,
   parameter int GOAL_Y  = 35
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] state,
   input  logic       move_tick,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_left,
   input  logic       key_right,
   output logic [5:0] query_col,
   output logic [5:0] query_row,
   input  logic       query_wall,
   output logic [5:0] player_x,
   output logic [5:0] player_y,
   output logic       busy,
   output logic       moved,
   output logic       blocked,
   output logic       goal
);

   localparam logic [5:0]        START_X_C = 6'(START_X);
   localparam logic [5:0]        START_Y_C = 6'(START_Y);
   localparam logic [5:0]        GOAL_X_C  = 6'(GOAL_X);
   localparam logic [5:0]        GOAL_Y_C  = 6'(GOAL_Y);
   localparam logic signed [6:0] MAX_POS   = 7'sd36;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      COMMIT = 2'd2
   } fsm_e;

   fsm_e       fsm_q, fsm_d;
   logic [3:0] idx_q, idx_d;
   logic [5:0] cand_x_q, cand_x_d;
   logic [5:0] cand_y_q, cand_y_d;
   logic [5:0] player_x_q, player_x_d;
   logic [5:0] player_y_q, player_y_d;
   logic       blocked_q, blocked_d;

   logic              in_stage;
   logic [2:0]        key_cnt;
   logic              req_ok;
   logic signed [6:0] dx, dy;
   logic signed [6:0] cand_x_w, cand_y_w;
   logic              cand_in_range;

   assign in_stage = (state == 4'd2) || (state == 4'd4) || (state == 4'd6);

   // Decode the key levels into a step vector and a signed candidate position.
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default
      // first, so no path through the block leaves it unassigned (no latch).
      req_ok   = 1'b0;
      dx       = '0;
      dy       = '0;
      key_cnt  = {2'b00, key_up} + {2'b00, key_down} + {2'b00, key_left} + {2'b00, key_right};
`ifdef DIAG_MOVE_EN
      // One key, or exactly one vertical plus one horizontal key.
      req_ok = (key_cnt == 3'd1) ||
               ((key_cnt == 3'd2) && (key_up ^ key_down) && (key_left ^ key_right));
`else
      req_ok = (key_cnt == 3'd1);
`endif
      if (key_right)     dx = 7'sd1;
      else if (key_left) dx = -7'sd1;
      if (key_down)      dy = 7'sd1;
      else if (key_up)   dy = -7'sd1;
      cand_x_w      = $signed({1'b0, player_x_q}) + dx;
      cand_y_w      = $signed({1'b0, player_y_q}) + dy;
      cand_in_range = (cand_x_w >= 7'sd0) && (cand_x_w <= MAX_POS) &&
                      (cand_y_w >= 7'sd0) && (cand_y_w <= MAX_POS);
   end

   // State and datapath registers; leaving the stage acts like reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before the edge, independent of statement order.
      if (!rst_n || !in_stage) begin
         fsm_q      <= IDLE;
         idx_q      <= '0;
         cand_x_q   <= START_X_C;
         cand_y_q   <= START_Y_C;
         player_x_q <= START_X_C;
         player_y_q <= START_Y_C;
         blocked_q  <= 1'b0;
      end else begin
         fsm_q      <= fsm_d;
         idx_q      <= idx_d;
         cand_x_q   <= cand_x_d;
         cand_y_q   <= cand_y_d;
         player_x_q <= player_x_d;
         player_y_q <= player_y_d;
         blocked_q  <= blocked_d;
      end
   end

   // Next-state logic: accept a request, walk the footprint scan, commit.
   always_comb begin
      fsm_d      = fsm_q;
      idx_d      = idx_q;
      cand_x_d   = cand_x_q;
      cand_y_d   = cand_y_q;
      player_x_d = player_x_q;
      player_y_d = player_y_q;
      blocked_d  = 1'b0;
      case (fsm_q)
         // The commit cycle already shows the new position, so it can take
         // the next request exactly like IDLE.
         IDLE, COMMIT: begin
            fsm_d = IDLE;
            if (move_tick && req_ok) begin
               if (cand_in_range) begin
                  fsm_d    = CHECK;
                  idx_d    = '0;
                  cand_x_d = cand_x_w[5:0];
                  cand_y_d = cand_y_w[5:0];
               end else begin
                  blocked_d = 1'b1;
               end
            end
         end
         CHECK: begin
            if (query_wall) begin
               fsm_d     = IDLE;
               blocked_d = 1'b1;
            end else if (idx_q == 4'd15) begin
               fsm_d      = COMMIT;
               player_x_d = cand_x_q;
               player_y_d = cand_y_q;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   // Output decode: scan address, busy flag and the commit/goal pulses.
   always_comb begin
      busy      = 1'b0;
      moved     = 1'b0;
      goal      = 1'b0;
      query_col = player_x_q;
      query_row = player_y_q;
      case (fsm_q)
         CHECK: begin
            busy      = 1'b1;
            query_col = cand_x_q + {4'b0000, idx_q[1:0]};
            query_row = cand_y_q + {4'b0000, idx_q[3:2]};
         end
         COMMIT: begin
            moved = 1'b1;
            goal  = (player_x_q == GOAL_X_C) && (player_y_q == GOAL_Y_C);
         end
         default: ;
      endcase
   end

   assign blocked  = blocked_q;
   assign player_x = player_x_q;
   assign player_y = player_y_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Directed testbench for player_ctrl: reset, range rejection, clear scan,
// wall abort, stage-exit abort, diagonal request and goal detection.
// Inputs change and outputs are sampled on the falling edge.

module tb_player_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] state;
   logic       move_tick;
   logic       key_up, key_down, key_left, key_right;
   logic [5:0] query_col, query_row;
   logic       query_wall;
   logic [5:0] player_x, player_y;
   logic       busy, moved, blocked, goal;

   // Single-cell bench map
   logic       wall_en;
   logic [5:0] wall_col, wall_row;

   int n_tests = 0;
   int n_fail  = 0;
   int cx, cy;

   localparam logic [3:0] K_UP    = 4'b1000;
   localparam logic [3:0] K_DOWN  = 4'b0100;
   localparam logic [3:0] K_LEFT  = 4'b0010;
   localparam logic [3:0] K_RIGHT = 4'b0001;

   always #5 clk = ~clk;

   assign query_wall = wall_en && (query_col == wall_col) && (query_row == wall_row);

   player_ctrl #(
      .START_X(1), .START_Y(1), .GOAL_X(35), .GOAL_Y(35)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .state      (state),
      .move_tick  (move_tick),
      .key_up     (key_up),
      .key_down   (key_down),
      .key_left   (key_left),
      .key_right  (key_right),
      .query_col  (query_col),
      .query_row  (query_row),
      .query_wall (query_wall),
      .player_x   (player_x),
      .player_y   (player_y),
      .busy       (busy),
      .moved      (moved),
      .blocked    (blocked),
      .goal       (goal)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a tick with the given {up,down,left,right} keys for one edge;
   // returns at the falling edge of cycle T+1.
   task automatic tick(input logic [3:0] k);
      {key_up, key_down, key_left, key_right} = k;
      move_tick = 1'b1;
      @(negedge clk);
      move_tick = 1'b0;
      {key_up, key_down, key_left, key_right} = 4'b0000;
   endtask

   // Full move on an open map: moved must arrive exactly at T+17.
   task automatic do_move(input logic [3:0] k, input int ex, input int ey);
      int n;
      tick(k);
      n = 1;
      while (!(moved === 1'b1 || blocked === 1'b1) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("walk_moved_latency", {moved, blocked, 6'(n)}, {1'b1, 1'b0, 6'd17});
      check("walk_pos", {player_x, player_y}, {6'(ex), 6'(ey)});
      check("walk_goal", goal, (ex == 35 && ey == 35));
      @(negedge clk);
      check("walk_pulse_end", {moved, goal, blocked}, 3'b000);
   endtask

   initial begin
      int pulses;
      rst_n     = 1'b0;
      state     = 4'd2;
      move_tick = 1'b0;
      {key_up, key_down, key_left, key_right} = 4'b0000;
      wall_en   = 1'b0;
      wall_col  = '0;
      wall_row  = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_pos", {player_x, player_y}, {6'd1, 6'd1});
      check("reset_query", {query_col, query_row}, {6'd1, 6'd1});
      check("reset_flags", {busy, moved, blocked, goal}, 4'b0000);
      rst_n = 1'b1;
      @(negedge clk);

      // Left from (1,1): x=0 is valid, scan runs
      tick(K_LEFT);
      check("left_busy_t1", busy, 1'b1);
      check("left_query_t1", {query_col, query_row}, {6'd0, 6'd1});
      repeat (16) @(negedge clk);
      check("left_moved_t17", {moved, blocked, busy}, 3'b100);
      check("left_pos_t17", {player_x, player_y}, {6'd0, 6'd1});
      @(negedge clk);
      check("left_pulse_end", moved, 1'b0);

      // Left from x=0: out of range, blocked at T+1 without scanning
      tick(K_LEFT);
      check("range_blocked_t1", {blocked, busy}, 2'b10);
      check("range_pos", {player_x, player_y}, {6'd0, 6'd1});
      @(negedge clk);
      check("range_blocked_end", {blocked, busy}, 2'b00);

      do_move(K_RIGHT, 1, 1);

      // Clear move right from (1,1): scan cols 2..5 rows 1..4 row-major
      tick(K_RIGHT);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("scan_cell_%0d", i), {busy, query_col, query_row},
               {1'b1, 6'(2 + i % 4), 6'(1 + i / 4)});
         @(negedge clk);
      end
      check("clear_moved_t17", {moved, blocked, busy, goal}, 4'b1000);
      check("clear_pos", {player_x, player_y}, {6'd2, 6'd1});
      check("idle_query_follows_pos", {query_col, query_row}, {6'd2, 6'd1});
      @(negedge clk);
      check("clear_pulse_end", moved, 1'b0);

      // Stage exit mid-scan: state goes to FAIL at edge T+5
      tick(K_DOWN);
      repeat (3) @(negedge clk);
      check("abort_busy_before", busy, 1'b1);
      state = 4'd8;
      @(negedge clk);
      check("abort_busy_t5", {busy, moved, blocked, goal}, 4'b0000);
      check("abort_pos_start", {player_x, player_y}, {6'd1, 6'd1});
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         pulses += int'(moved) + int'(blocked) + int'(goal) + int'(busy);
      end
      check("abort_no_pulse", pulses, 0);
      state = 4'd2;
      @(negedge clk);
      check("abort_reentry_pos", {player_x, player_y, busy}, {6'd1, 6'd1, 1'b0});

      // Wall at (5,2) hit at i=7 on a right move from (1,1)
      wall_en  = 1'b1;
      wall_col = 6'd5;
      wall_row = 6'd2;
      tick(K_RIGHT);
      repeat (7) @(negedge clk);
      check("wall_query_t8", {busy, query_col, query_row}, {1'b1, 6'd5, 6'd2});
      @(negedge clk);
      check("wall_blocked_t9", {blocked, busy, moved}, 3'b100);
      check("wall_pos", {player_x, player_y}, {6'd1, 6'd1});
      @(negedge clk);
      check("wall_blocked_end", blocked, 1'b0);
      wall_en = 1'b0;

      // Opposing keys: no action
      tick(K_LEFT | K_RIGHT);
      check("opposing_none", {busy, blocked}, 2'b00);
      @(negedge clk);

      // Walk to (5,5) for the diagonal request
      cx = 1;
      cy = 1;
      while (cx < 5) begin cx++; do_move(K_RIGHT, cx, cy); end
      while (cy < 5) begin cy++; do_move(K_DOWN, cx, cy); end

      tick(K_UP | K_RIGHT);
`ifdef DIAG_MOVE_EN
      check("diag_busy_t1", busy, 1'b1);
      repeat (16) @(negedge clk);
      check("diag_moved_t17", moved, 1'b1);
      check("diag_pos", {player_x, player_y}, {6'd6, 6'd4});
      cx = 6;
      cy = 4;
`else
      check("diag_busy_t1", {busy, blocked}, 2'b00);
      repeat (16) @(negedge clk);
      check("diag_moved_t17", moved, 1'b0);
      check("diag_pos", {player_x, player_y}, {6'd5, 6'd5});
`endif
      @(negedge clk);

      // Walk to (34,35) then step right onto the goal
      while (cx < 34) begin cx++; do_move(K_RIGHT, cx, cy); end
      while (cy < 35) begin cy++; do_move(K_DOWN, cx, cy); end
      check("pre_goal_pos", {player_x, player_y}, {6'd34, 6'd35});
      do_move(K_RIGHT, 35, 35);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
